imem_fetch_ctrl: RTL and testbench

IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

---
 rtl/imem_pkg.sv | 22 ++
 rtl/imem_fetch_ctrl.sv | 148 ++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory fetch controller.
// Holds the controller state encoding and the default geometry constants.
// No logic lives here; the controller imports it.
package imem_pkg;

    // Default instruction word width in bits
    localparam int WIDTH = 32;
    // Default number of instruction-memory words
    localparam int DEPTH = 80;
    // Default PC / address width in bits
    localparam int ADR_IN = 64;
    // Default byte PC that execution starts from after a load
    localparam logic [63:0] RESET_PC = 64'd0;

    // Controller phases: fill memory, fetch instructions, stopped on a fault
    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory controller: streams loader words into memory, then fetches sequentially from RESET_PC.
// Latency: one cycle from pc presented on mem_adr to out_instr/out_pc/out_valid.
// Backpressure: out_valid & !out_ready holds output and pc; redirect overrides a stall; load_ready drops when memory is full.
module imem_fetch_ctrl
    import imem_pkg::*;
#(
    parameter int                  WIDTH    = imem_pkg::WIDTH,
    parameter int                  DEPTH    = imem_pkg::DEPTH,
    parameter int                  ADR_IN   = imem_pkg::ADR_IN,
    parameter logic [ADR_IN-1:0]   RESET_PC = ADR_IN'(imem_pkg::RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [WIDTH-1:0]  load_data,
    input  logic              load_done,
    output logic              load_ready,
    output logic              mem_we,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic [ADR_IN-1:0] mem_adr,
    input  logic [WIDTH-1:0]  mem_instr,
    input  logic              redirect_valid,
    input  logic [ADR_IN-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_instr,
    output logic [ADR_IN-1:0] out_pc,
    output logic              fault,
    output logic              busy_load
);

    // Load counter must be able to hold DEPTH itself (memory full)
    localparam int                CNT_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEPTH - 1);
    localparam logic [ADR_IN-1:0] DEPTH_A  = ADR_IN'(DEPTH);
    localparam logic [ADR_IN-1:0] PC_STEP  = ADR_IN'(4);

    fetch_state_t       state_q,     state_d;
    logic [CNT_W-1:0]   load_cnt_q,  load_cnt_d;
    logic [ADR_IN-1:0]  pc_q,        pc_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_instr_q, out_instr_d;
    logic [ADR_IN-1:0]  out_pc_q,    out_pc_d;
    logic               fault_q,     fault_d;
    logic               wr_en;
    logic               stall;

    // A fetch address is illegal if it is not word aligned or lies past the last word
    function automatic logic pc_bad(input logic [ADR_IN-1:0] p);
        return (p[1:0] != 2'b00) || ((p >> 2) >= DEPTH_A);
    endfunction

    // State and datapath registers; reset aborts any load or fetch but leaves memory alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LOAD;
            load_cnt_q  <= '0;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            fault_q     <= fault_d;
        end
    end

    // Next-state and memory-port decode for the LOAD / RUN / HALT phases
    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        fault_d     = fault_q;
        load_ready  = 1'b0;
        wr_en       = 1'b0;
        mem_adr     = pc_q >> 2;
        mem_wdata   = load_data;
        stall       = out_valid_q & ~out_ready;

        case (state_q)
            LOAD: begin
                load_ready = (load_cnt_q < CNT_FULL);
                wr_en      = load_valid & load_ready;
                mem_adr    = ADR_IN'(load_cnt_q);
                if (wr_en) begin
                    load_cnt_d = load_cnt_q + 1'b1;
                end
                // A word written alongside load_done is still stored; RUN starts clean
                if (load_done || (wr_en && (load_cnt_q == CNT_LAST))) begin
                    state_d     = RUN;
                    pc_d        = RESET_PC;
                    out_valid_d = 1'b0;
                end
            end

            RUN: begin
                if (redirect_valid) begin
                    // Redirect wins over a stall; the pending instruction is dropped
                    pc_d        = redirect_pc;
                    out_valid_d = 1'b0;
                end else if (stall) begin
                    // Decode is not taking the current instruction: hold everything
                    pc_d        = pc_q;
                end else if (pc_bad(pc_q)) begin
                    state_d     = HALT;
                    fault_d     = 1'b1;
                    out_valid_d = 1'b0;
                end else begin
                    out_valid_d = 1'b1;
                    out_instr_d = mem_instr;
                    out_pc_d    = pc_q;
                    pc_d        = pc_q + PC_STEP;
                end
            end

            HALT: begin
                // Only reset leaves HALT; redirects and loader traffic are ignored
                out_valid_d = 1'b0;
                fault_d     = 1'b1;
            end

            default: begin
                state_d     = HALT;
                out_valid_d = 1'b0;
                fault_d     = 1'b1;
            end
        endcase
    end

    // Write strobe is forced low while reset is held so no stray write escapes
    assign mem_we    = wr_en & ~rst;
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_pc    = out_pc_q;
    assign fault     = fault_q;
    assign busy_load = (state_q == LOAD);

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: external memory model, reference image of loaded words and a
// transaction-level view of the fetch stream (next expected PC, pending slot held under stall).
// Random full load and random RUN traffic first, then directed load / stall / redirect / fault / reset steps.
module tb_imem_fetch_ctrl;

    localparam int W = 32;
    localparam int D = 80;
    localparam int A = 64;

    logic          clk;
    logic          rst;
    logic          load_valid;
    logic [W-1:0]  load_data;
    logic          load_done;
    logic          load_ready;
    logic          mem_we;
    logic [W-1:0]  mem_wdata;
    logic [A-1:0]  mem_adr;
    logic [W-1:0]  mem_instr;
    logic          redirect_valid;
    logic [A-1:0]  redirect_pc;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_instr;
    logic [A-1:0]  out_pc;
    logic          fault;
    logic          busy_load;

    logic [W-1:0]  mem     [0:D-1];
    logic [W-1:0]  ref_mem [0:D-1];

    int vectors     = 0;
    int miscompares = 0;

    imem_fetch_ctrl #(
        .WIDTH    (W),
        .DEPTH    (D),
        .ADR_IN   (A),
        .RESET_PC (64'd0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .load_valid     (load_valid),
        .load_data      (load_data),
        .load_done      (load_done),
        .load_ready     (load_ready),
        .mem_we         (mem_we),
        .mem_wdata      (mem_wdata),
        .mem_adr        (mem_adr),
        .mem_instr      (mem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fault          (fault),
        .busy_load      (busy_load)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External instruction memory: synchronous write, combinational read
    always @(posedge clk) begin
        if (mem_we && (mem_adr < 64'(D))) mem[mem_adr[6:0]] <= mem_wdata;
    end
    assign mem_instr = (mem_adr < 64'(D)) ? mem[mem_adr[6:0]] : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reset pulse entirely between clock edges; outputs must react without an edge
    task automatic async_reset;
        load_valid     = 1'b0;
        load_done      = 1'b0;
        redirect_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_pc",    out_pc,         64'd0);
        chk("arst_out_instr", 64'(out_instr), 64'd0);
        chk("arst_fault",     64'(fault),     64'd0);
        chk("arst_busy_load", 64'(busy_load), 64'd1);
        chk("arst_mem_we",    64'(mem_we),    64'd0);
        #1 rst = 1'b0;
        #1;
        chk("rel_load_ready", 64'(load_ready), 64'd1);
        chk("rel_load_cnt",   mem_adr,         64'd0);
        chk("rel_busy_load",  64'(busy_load),  64'd1);
    endtask

    initial begin
        int           cnt;
        bit           lv;
        bit           do_rd;
        bit           stalled;
        bit           cur_v;
        logic [63:0]  cur_pc;
        logic [31:0]  cur_instr;
        logic [63:0]  exp_pc;
        logic [63:0]  tgt;

        rst            = 1'b1;
        load_valid     = 1'b1;
        load_data      = 32'h1234_5678;
        load_done      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;

        // Reset state, before any clock edge
        #3;
        chk("rst_out_valid",  64'(out_valid),  64'd0);
        chk("rst_out_pc",     out_pc,          64'd0);
        chk("rst_out_instr",  64'(out_instr),  64'd0);
        chk("rst_fault",      64'(fault),      64'd0);
        chk("rst_busy_load",  64'(busy_load),  64'd1);
        chk("rst_mem_we",     64'(mem_we),     64'd0);
        load_valid = 1'b0;
        #9 rst = 1'b0;
        #1;
        chk("rst_load_ready", 64'(load_ready), 64'd1);
        chk("rst_load_cnt",   mem_adr,         64'd0);

        // Fill every word with random data and gaps; the last word ends LOAD on its own
        cnt = 0;
        while (cnt < D) begin
            lv         = ($urandom_range(0, 3) != 0);
            load_valid = lv;
            load_data  = $urandom;
            #1;
            chk("fill_mem_we",     64'(mem_we),     64'(lv));
            chk("fill_adr",        mem_adr,         64'(cnt));
            chk("fill_load_ready", 64'(load_ready), 64'd1);
            if (lv) begin
                ref_mem[cnt] = load_data;
                cnt++;
            end
            tick;
        end
        load_valid = 1'b0;
        #1;
        chk("fill_run_busy",   64'(busy_load),  64'd0);
        chk("fill_run_valid",  64'(out_valid),  64'd0);
        chk("fill_run_pc",     mem_adr,         64'd0);
        chk("fill_run_ready",  64'(load_ready), 64'd0);

        // Random fetch traffic: random backpressure, random in-range redirects, loader noise
        cur_v     = 1'b0;
        cur_pc    = '0;
        cur_instr = '0;
        exp_pc    = 64'd0;
        for (int n = 0; n < 400; n++) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            do_rd          = ($urandom_range(0, 7) == 0) || (exp_pc >= 64'd304);
            tgt            = 64'($urandom_range(0, D - 1)) << 2;
            redirect_valid = do_rd;
            redirect_pc    = tgt;
            load_valid     = 1'($urandom_range(0, 1));
            load_done      = 1'($urandom_range(0, 1));
            load_data      = $urandom;
            #1;
            chk("run_mem_we",     64'(mem_we),     64'd0);
            chk("run_load_ready", 64'(load_ready), 64'd0);
            chk("run_adr",        mem_adr,         exp_pc >> 2);
            stalled = cur_v && !out_ready;
            tick;
            if (do_rd) begin
                chk("run_rd_bubble", 64'(out_valid), 64'd0);
                exp_pc = tgt;
                cur_v  = 1'b0;
            end else if (stalled) begin
                chk("run_hold_valid", 64'(out_valid), 64'd1);
                chk("run_hold_pc",    out_pc,         cur_pc);
                chk("run_hold_instr", 64'(out_instr), 64'(cur_instr));
            end else begin
                cur_v     = 1'b1;
                cur_pc    = exp_pc;
                cur_instr = ref_mem[exp_pc[8:2]];
                exp_pc    = exp_pc + 64'd4;
                chk("run_valid", 64'(out_valid), 64'd1);
                chk("run_pc",    out_pc,         cur_pc);
                chk("run_instr", 64'(out_instr), 64'(cur_instr));
            end
            chk("run_fault", 64'(fault), 64'd0);
        end
        load_valid = 1'b0;
        load_done  = 1'b0;

        // Reset in the middle of RUN, then load 0..9 with load_done on the last word
        async_reset;
        for (int i = 0; i < 10; i++) begin
            load_valid = 1'b1;
            load_data  = 32'(i);
            load_done  = (i == 9);
            #1;
            chk("ld10_mem_we", 64'(mem_we),    64'd1);
            chk("ld10_adr",    mem_adr,        64'(i));
            chk("ld10_busy",   64'(busy_load), 64'd1);
            ref_mem[i] = 32'(i);
            tick;
        end
        load_valid = 1'b0;
        load_done  = 1'b0;
        #1;
        chk("ld10_busy_fall", 64'(busy_load), 64'd0);
        chk("ld10_run_valid", 64'(out_valid), 64'd0);

        // Free-running fetch of the ten loaded words
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick;
            chk("seq_valid", 64'(out_valid), 64'd1);
            chk("seq_pc",    out_pc,         64'(4 * k));
            chk("seq_instr", 64'(out_instr), 64'(k));
        end

        // Back to 8, stall three cycles, then resume with 12
        redirect_valid = 1'b1;
        redirect_pc    = 64'd8;
        tick;
        redirect_valid = 1'b0;
        chk("rd8_bubble", 64'(out_valid), 64'd0);
        tick;
        chk("rd8_pc",    out_pc,         64'd8);
        chk("rd8_instr", 64'(out_instr), 64'd2);
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick;
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_pc",    out_pc,         64'd8);
            chk("stall_instr", 64'(out_instr), 64'd2);
            chk("stall_adr",   mem_adr,        64'd3);
        end
        out_ready = 1'b1;
        tick;
        chk("resume_pc",    out_pc,         64'd12);
        chk("resume_instr", 64'(out_instr), 64'd3);

        // Redirect to 20 while stalled at 8
        redirect_valid = 1'b1;
        redirect_pc    = 64'd8;
        tick;
        redirect_valid = 1'b0;
        tick;
        chk("rd8b_pc", out_pc, 64'd8);
        out_ready = 1'b0;
        tick;
        chk("rd8b_hold", out_pc, 64'd8);
        redirect_valid = 1'b1;
        redirect_pc    = 64'd20;
        tick;
        redirect_valid = 1'b0;
        chk("rd20_bubble", 64'(out_valid), 64'd0);
        tick;
        chk("rd20_valid", 64'(out_valid), 64'd1);
        chk("rd20_pc",    out_pc,         64'd20);
        chk("rd20_instr", 64'(out_instr), 64'd5);
        out_ready = 1'b1;

        // Misaligned redirect target faults on the following fetch and sticks
        redirect_valid = 1'b1;
        redirect_pc    = 64'd6;
        tick;
        redirect_valid = 1'b0;
        chk("mis_bubble",      64'(out_valid), 64'd0);
        chk("mis_fault_early", 64'(fault),     64'd0);
        tick;
        chk("mis_fault", 64'(fault),     64'd1);
        chk("mis_valid", 64'(out_valid), 64'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 64'd20;
        load_valid     = 1'b1;
        load_done      = 1'b1;
        for (int h = 0; h < 4; h++) begin
            tick;
            chk("halt_fault",  64'(fault),      64'd1);
            chk("halt_valid",  64'(out_valid),  64'd0);
            chk("halt_we",     64'(mem_we),     64'd0);
            chk("halt_ready",  64'(load_ready), 64'd0);
            chk("halt_busy",   64'(busy_load),  64'd0);
        end

        // Reset, skip loading: memory keeps the earlier image, last word is reachable, 320 faults
        async_reset;
        load_done = 1'b1;
        tick;
        load_done = 1'b0;
        chk("keep_busy",  64'(busy_load), 64'd0);
        chk("keep_valid", 64'(out_valid), 64'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 64'd40;
        tick;
        redirect_valid = 1'b0;
        tick;
        chk("keep_pc",    out_pc,         64'd40);
        chk("keep_instr", 64'(out_instr), 64'(ref_mem[10]));
        redirect_valid = 1'b1;
        redirect_pc    = 64'd316;
        tick;
        redirect_valid = 1'b0;
        tick;
        chk("last_pc",    out_pc,         64'd316);
        chk("last_instr", 64'(out_instr), 64'(ref_mem[79]));
        tick;
        chk("runoff_fault", 64'(fault),     64'd1);
        chk("runoff_valid", 64'(out_valid), 64'd0);

        async_reset;
        load_done = 1'b1;
        tick;
        load_done      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'd320;
        tick;
        redirect_valid = 1'b0;
        chk("oor_bubble",      64'(out_valid), 64'd0);
        chk("oor_fault_early", 64'(fault),     64'd0);
        tick;
        chk("oor_fault", 64'(fault),     64'd1);
        chk("oor_valid", 64'(out_valid), 64'd0);
        for (int h = 0; h < 3; h++) begin
            tick;
            chk("oor_hold_fault", 64'(fault),     64'd1);
            chk("oor_hold_valid", 64'(out_valid), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
